// File: rtl/wr_pulse_scheduler.sv
// Replays received trigger timestamps as fixed-width pulses once WR time reaches timestamp + delay.
// Build option: define WR_PULSE_SCHED_LATE_FIRE_EN to fire slightly late deadlines instead of dropping them.
module wr_pulse_scheduler #(
   parameter int unsigned g_queue_depth    = 8,
   parameter int unsigned g_delay_cycles   = 2500,
   parameter int unsigned g_pulse_width    = 125,
   parameter int unsigned g_cycles_per_sec = 125000000,
   parameter int unsigned g_late_window    = 250
) (
   input  logic        clk_sys_i,
   input  logic        rst_n_i,
   input  logic        enable_i,
   input  logic        tm_time_valid_i,
   input  logic [39:0] tm_tai_i,
   input  logic [27:0] tm_cycles_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   input  logic [39:0] rx_tai_i,
   input  logic [27:0] rx_cycles_i,
   input  logic        clear_stats_i,
   output logic        pulse_o,
   output logic [15:0] cnt_fired_o,
   output logic [15:0] cnt_missed_o,
   output logic        overflow_o
);
   // state  | meaning
   // S_IDLE | queue empty or time invalid, nothing scheduled
   // S_WAIT | comparing head deadline against current time
   // S_FIRE | driving pulse_o, width timer counting down
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FIRE} state_t;

   localparam int unsigned AW  = (g_queue_depth > 1) ? $clog2(g_queue_depth) : 1;
   localparam int unsigned PWW = $clog2(g_pulse_width + 1);
   localparam logic [28:0] DELAY = 29'(g_delay_cycles);
   localparam logic [28:0] CPS   = 29'(g_cycles_per_sec);

   state_t          state;
   logic [PWW-1:0]  width_cnt;
   logic            up_q;
   logic            run;
   logic            accept;
   logic            malformed;
   logic [28:0]     sum;
   logic            wrap;
   logic            s1_valid;
   logic [39:0]     s1_tai;
   logic [27:0]     s1_cyc;
   logic [67:0]     mem [g_queue_depth];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     fifo_cnt;
   logic            push, pop;
   logic [67:0]     now, head;
   logic            d_eq, d_lt, late_ok;
   logic            fire_done, miss_wait, miss_rx;

   assign run       = enable_i & tm_time_valid_i;
   assign rx_ready_o = up_q & run &
                       (({1'b0, fifo_cnt} + (AW+2)'(s1_valid)) < (AW+2)'(g_queue_depth));
   assign accept    = rx_valid_i & rx_ready_o;
   assign malformed = {1'b0, rx_cycles_i} >= CPS;
   assign sum       = {1'b0, rx_cycles_i} + DELAY;
   assign wrap      = sum >= CPS;

   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) up_q <= 1'b0;
      else          up_q <= 1'b1;
   end

   // Stage 1: deadline arithmetic, carry into TAI on second rollover
   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_valid <= 1'b0;
         s1_tai   <= '0;
         s1_cyc   <= '0;
      end else begin
         s1_valid <= run & accept & ~malformed;
         if (accept) begin
            s1_tai <= wrap ? rx_tai_i + 40'd1 : rx_tai_i;
            s1_cyc <= wrap ? 28'(sum - CPS) : sum[27:0];
         end
      end
   end

   assign push = s1_valid & run;
   assign now  = {tm_tai_i, tm_cycles_i};
   assign head = mem[rd_ptr];
   assign d_eq = now == head;
   assign d_lt = now < head;
   assign pop  = run & (state == S_WAIT) & (fifo_cnt != '0) & ~d_lt;

`ifdef WR_PULSE_SCHED_LATE_FIRE_EN
   logic [67:0] lateness;
   assign lateness = now - head;
   assign late_ok  = ~d_eq & ~d_lt & (lateness <= 68'(g_late_window));
`else
   // the window has no effect in this build; the term folds to zero
   assign late_ok = 1'b0 & (g_late_window != 0);
`endif

   always_ff @(posedge clk_sys_i) begin
      if (push) mem[wr_ptr] <= {s1_tai, s1_cyc};
   end

   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else if (!run) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         wr_ptr   <= wr_ptr + AW'(push);
         rd_ptr   <= rd_ptr + AW'(pop);
         fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= S_IDLE;
         pulse_o   <= 1'b0;
         width_cnt <= '0;
      end else if (!run) begin
         state   <= S_IDLE;
         pulse_o <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (fifo_cnt != '0) state <= S_WAIT;
            S_WAIT: begin
               if (fifo_cnt == '0) state <= S_IDLE;
               else if (!d_lt) begin
                  if (d_eq || late_ok) begin
                     state     <= S_FIRE;
                     pulse_o   <= 1'b1;
                     width_cnt <= PWW'(g_pulse_width - 1);
                  end else if (fifo_cnt == (AW+1)'(1)) begin
                     state <= S_IDLE;
                  end
               end
            end
            S_FIRE: begin
               if (width_cnt == '0) begin
                  pulse_o <= 1'b0;
                  state   <= (fifo_cnt != '0) ? S_WAIT : S_IDLE;
               end else begin
                  width_cnt <= width_cnt - 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign fire_done = run & (state == S_FIRE) & (width_cnt == '0);
   assign miss_wait = pop & ~d_eq & ~late_ok;
   assign miss_rx   = accept & malformed;

   function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] inc);
      logic [16:0] s;
      s = {1'b0, v} + {15'd0, inc};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_fired_o  <= '0;
         cnt_missed_o <= '0;
         overflow_o   <= 1'b0;
      end else if (clear_stats_i) begin
         cnt_fired_o  <= '0;
         cnt_missed_o <= '0;
         overflow_o   <= 1'b0;
      end else begin
         cnt_fired_o  <= sat_add(cnt_fired_o, {1'b0, fire_done});
         cnt_missed_o <= sat_add(cnt_missed_o, 2'(miss_rx) + 2'(miss_wait));
         if (rx_valid_i && !rx_ready_o) overflow_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_wr_pulse_scheduler.sv
// Directed bench for wr_pulse_scheduler: delay path, second carry, late/malformed drops,
// full queue with overflow, time-valid flush and reset during a pulse.
module tb_wr_pulse_scheduler;
   localparam int unsigned CPS = 125000000;

   logic        clk_sys_i = 1'b0;
   logic        rst_n_i;
   logic        enable_i;
   logic        tm_time_valid_i;
   logic [39:0] tm_tai;
   logic [27:0] tm_cyc;
   logic        rx_valid_i;
   logic        rx_ready_o;
   logic [39:0] rx_tai_i;
   logic [27:0] rx_cycles_i;
   logic        clear_stats_i;
   logic        pulse_o;
   logic [15:0] cnt_fired_o;
   logic [15:0] cnt_missed_o;
   logic        overflow_o;

   int          n_tests = 0;
   int          n_fail  = 0;
   bit          tm_run;
   bit          pulse_prev;
   int          high_cnt;
   logic [67:0] rises[$];
   int          widths[$];

   always #4 clk_sys_i = ~clk_sys_i;

   wr_pulse_scheduler dut (
      .clk_sys_i       (clk_sys_i),
      .rst_n_i         (rst_n_i),
      .enable_i        (enable_i),
      .tm_time_valid_i (tm_time_valid_i),
      .tm_tai_i        (tm_tai),
      .tm_cycles_i     (tm_cyc),
      .rx_valid_i      (rx_valid_i),
      .rx_ready_o      (rx_ready_o),
      .rx_tai_i        (rx_tai_i),
      .rx_cycles_i     (rx_cycles_i),
      .clear_stats_i   (clear_stats_i),
      .pulse_o         (pulse_o),
      .cnt_fired_o     (cnt_fired_o),
      .cnt_missed_o    (cnt_missed_o),
      .overflow_o      (overflow_o)
   );

   task automatic check_val(input string tag, input logic [67:0] got, input logic [67:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // one clock: advance WR time on the falling edge, then log pulse edges/widths
   task automatic step();
      @(negedge clk_sys_i);
      if (tm_run) begin
         if (tm_cyc == 28'(CPS - 1)) begin
            tm_cyc = '0;
            tm_tai = tm_tai + 40'd1;
         end else begin
            tm_cyc = tm_cyc + 28'd1;
         end
      end
      if (pulse_o && !pulse_prev) begin
         rises.push_back({tm_tai, tm_cyc});
         high_cnt = 1;
      end else if (pulse_o) begin
         high_cnt++;
      end else if (pulse_prev) begin
         widths.push_back(high_cnt);
      end
      pulse_prev = pulse_o;
   endtask

   task automatic run_cycles(input int n);
      repeat (n) step();
   endtask

   task automatic push_ts(input logic [39:0] tai, input logic [27:0] cyc);
      rx_valid_i  = 1'b1;
      rx_tai_i    = tai;
      rx_cycles_i = cyc;
      step();
      rx_valid_i  = 1'b0;
   endtask

   task automatic clear_stats();
      clear_stats_i = 1'b1;
      step();
      clear_stats_i = 1'b0;
   endtask

   task automatic clear_log();
      rises.delete();
      widths.delete();
   endtask

   initial begin
      logic [15:0] fired_before, missed_before;
      int exp_fired, exp_missed;

      rst_n_i = 1'b0;
      enable_i = 1'b1;
      tm_time_valid_i = 1'b1;
      tm_tai = 40'd10;
      tm_cyc = 28'd3400;
      tm_run = 1'b1;
      rx_valid_i = 1'b0;
      rx_tai_i = '0;
      rx_cycles_i = '0;
      clear_stats_i = 1'b0;
      pulse_prev = 1'b0;
      high_cnt = 0;

      #1;
      check_val("rst_pulse", 68'(pulse_o), 68'd0);
      check_val("rst_ready", 68'(rx_ready_o), 68'd0);
      check_val("rst_fired", 68'(cnt_fired_o), 68'd0);
      check_val("rst_missed", 68'(cnt_missed_o), 68'd0);
      check_val("rst_ovf", 68'(overflow_o), 68'd0);
      run_cycles(3);
      rst_n_i = 1'b1;
      #1;
      check_val("rel_ready0", 68'(rx_ready_o), 68'd0);
      step();
      check_val("rel_ready1", 68'(rx_ready_o), 68'd1);

      // 1. delay path
      push_ts(40'd10, 28'd1000);
      run_cycles(250);
      check_val("t1_nrise", 68'(rises.size()), 68'd1);
      if (rises.size() > 0) check_val("t1_rise", rises[0], {40'd10, 28'd3501});
      if (widths.size() > 0) check_val("t1_width", 68'(widths[0]), 68'd125);
      check_val("t1_fired", 68'(cnt_fired_o), 68'd1);
      clear_log();

      // 2. deadline crosses a second boundary
      tm_tai = 40'd10;
      tm_cyc = 28'd124999900;
      push_ts(40'd10, 28'd124999000);
      run_cycles(1800);
      check_val("t2_nrise", 68'(rises.size()), 68'd1);
      if (rises.size() > 0) check_val("t2_rise", rises[0], {40'd11, 28'd1501});
      check_val("t2_fired", 68'(cnt_fired_o), 68'd2);
      clear_log();

      // 3. late trigger and malformed cycles field
      clear_stats();
      tm_tai = 40'd30;
      tm_cyc = 28'd5000;
      push_ts(40'd30, 28'd2490);
      run_cycles(300);
`ifdef WR_PULSE_SCHED_LATE_FIRE_EN
      exp_fired = 1;
      exp_missed = 0;
`else
      exp_fired = 0;
      exp_missed = 1;
`endif
      check_val("t3_fired", 68'(cnt_fired_o), 68'(exp_fired));
      check_val("t3_missed", 68'(cnt_missed_o), 68'(exp_missed));
      check_val("t3_nrise", 68'(rises.size()), 68'(exp_fired));
      push_ts(40'd30, 28'd125000000);
      run_cycles(5);
      check_val("t3_malformed", 68'(cnt_missed_o), 68'(exp_missed + 1));
      check_val("t3_mal_fired", 68'(cnt_fired_o), 68'(exp_fired));
      clear_log();

      // 4. full queue with frozen time
      tm_run = 1'b0;
      tm_tai = 40'd20;
      tm_cyc = 28'd0;
      for (int i = 0; i < 9; i++) begin
         if (i == 8) check_val("t4_ready_full", 68'(rx_ready_o), 68'd0);
         rx_valid_i  = 1'b1;
         rx_tai_i    = 40'd20;
         rx_cycles_i = 28'(200 * i);
         step();
      end
      rx_valid_i = 1'b0;
      check_val("t4_ovf", 68'(overflow_o), 68'd1);
      check_val("t4_lost_not_missed", 68'(cnt_missed_o), 68'(exp_missed + 1));
      clear_stats();
      check_val("t4_ovf_clr", 68'(overflow_o), 68'd0);
      check_val("t4_missed_clr", 68'(cnt_missed_o), 68'd0);
      tm_cyc = 28'd2400;
      tm_run = 1'b1;
      run_cycles(1800);
      check_val("t4_nrise", 68'(rises.size()), 68'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < rises.size()) check_val($sformatf("t4_rise%0d", i), rises[i], {40'd20, 28'(2501 + 200 * i)});
         if (i < widths.size()) check_val($sformatf("t4_width%0d", i), 68'(widths[i]), 68'd125);
      end
      check_val("t4_fired", 68'(cnt_fired_o), 68'd8);
      check_val("t4_ready_back", 68'(rx_ready_o), 68'd1);
      clear_log();

      // 5. time valid drops mid-pulse with three entries still queued
      tm_tai = 40'd40;
      tm_cyc = 28'd2500;
      for (int i = 0; i < 4; i++) push_ts(40'd40, 28'(100 + 200 * i));
      run_cycles(150);
      check_val("t5_pulse_on", 68'(pulse_o), 68'd1);
      fired_before  = cnt_fired_o;
      missed_before = cnt_missed_o;
      tm_time_valid_i = 1'b0;
      step();
      check_val("t5_pulse_off", 68'(pulse_o), 68'd0);
      check_val("t5_ready_off", 68'(rx_ready_o), 68'd0);
      tm_time_valid_i = 1'b1;
      run_cycles(1200);
      check_val("t5_nrise", 68'(rises.size()), 68'd1);
      check_val("t5_fired", 68'(cnt_fired_o), 68'(fired_before));
      check_val("t5_missed", 68'(cnt_missed_o), 68'(missed_before));
      clear_log();

      // 6. reset during a pulse
      tm_tai = 40'd50;
      tm_cyc = 28'd2400;
      push_ts(40'd50, 28'd0);
      run_cycles(150);
      check_val("t6_pulse_on", 68'(pulse_o), 68'd1);
      rst_n_i = 1'b0;
      #1;
      check_val("t6_pulse", 68'(pulse_o), 68'd0);
      check_val("t6_ready", 68'(rx_ready_o), 68'd0);
      check_val("t6_fired", 68'(cnt_fired_o), 68'd0);
      check_val("t6_missed", 68'(cnt_missed_o), 68'd0);
      run_cycles(3);
      rst_n_i = 1'b1;
      #1;
      check_val("t6_rel_ready0", 68'(rx_ready_o), 68'd0);
      step();
      check_val("t6_rel_ready1", 68'(rx_ready_o), 68'd1);
      run_cycles(300);
      check_val("t6_no_refire", 68'(cnt_fired_o), 68'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
